// File: rtl/fc_pkg.sv
// Shared constants, sizing helpers and FSM state type for the FC result writer.
package fc_pkg;

   localparam int DIM_OUTPUT_DEF = 8;
   localparam int OUTPUT_W_DEF   = 8;
   localparam int BRAM_DAT_W_DEF = 32;

   function automatic int calc_words(input int dim, input int ow, input int bw);
      return (dim * ow) / bw;
   endfunction

   function automatic int calc_step(input int bw);
      return bw / 8;
   endfunction

   localparam int WORDS = calc_words(DIM_OUTPUT_DEF, OUTPUT_W_DEF, BRAM_DAT_W_DEF);
   localparam int STEP  = calc_step(BRAM_DAT_W_DEF);

   localparam logic [15:0] TAIL_MAGIC = 16'hFC5A;

   typedef enum logic [2:0] {
      IDLE,
      ACCEPT,
      WRITE,
      TAIL,
      DONE
   } fc_state_t;

endpackage

// File: rtl/fc_result_writer_word_slicer.sv
// Combinational packer: flattens the captured vector (element 0 in the LSBs) and returns word k.
module fc_word_slicer
   import fc_pkg::*;
#(
   parameter int DIM_OUTPUT = DIM_OUTPUT_DEF,
   parameter int OUTPUT_W   = OUTPUT_W_DEF,
   parameter int BRAM_DAT_W = BRAM_DAT_W_DEF,
   parameter int WORDS_N    = calc_words(DIM_OUTPUT, OUTPUT_W, BRAM_DAT_W),
   parameter int KW         = (WORDS_N > 1) ? $clog2(WORDS_N) : 1
) (
   input  logic [OUTPUT_W-1:0]   vec [DIM_OUTPUT],
   input  logic [KW-1:0]         k,
   output logic [BRAM_DAT_W-1:0] word
);

   logic [DIM_OUTPUT*OUTPUT_W-1:0] flat;

   always_comb begin
      flat = '0;
      for (int i = 0; i < DIM_OUTPUT; i++) begin
         flat[i*OUTPUT_W +: OUTPUT_W] = vec[i];
      end
      word = '0;
      for (int j = 0; j < WORDS_N; j++) begin
         if (k == KW'(j)) begin
            word = flat[j*BRAM_DAT_W +: BRAM_DAT_W];
         end
      end
   end

endmodule

// File: rtl/fc_result_writer.sv
// FC result sink: packs each output vector into BRAM words and tracks batch completion.
// Optional FC_RESULT_TAIL_EN appends a status word after the last vector of a batch.
module fc_result_writer
   import fc_pkg::*;
#(
   parameter int DIM_OUTPUT = DIM_OUTPUT_DEF,
   parameter int OUTPUT_W   = OUTPUT_W_DEF,
   parameter int BRAM_DAT_W = BRAM_DAT_W_DEF,
   parameter int ADDR_SW    = 12,
   parameter int BATCH_NUM  = 10,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [OUTPUT_W-1:0]   vec_dat [DIM_OUTPUT],
   input  logic                  vec_vld,
   output logic                  vec_rdy,
   output logic [ADDR_SW-1:0]    bram_addr,
   output logic [BRAM_DAT_W-1:0] bram_din,
   output logic                  bram_en,
   output logic                  bram_we,
   output logic                  busy,
   output logic                  done,
   input  logic                  done_ack,
   output logic                  err_drop
);

   localparam int NWORDS = calc_words(DIM_OUTPUT, OUTPUT_W, BRAM_DAT_W);
   localparam int NSTEP  = calc_step(BRAM_DAT_W);
   localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int CW     = $clog2(BATCH_NUM + 1);
`ifdef FC_RESULT_TAIL_EN
   localparam int TAIL_WORDS = 1;
`else
   localparam int TAIL_WORDS = 0;
`endif
   localparam longint SPAN = longint'(BASE_ADDR)
                           + longint'(BATCH_NUM * NWORDS + TAIL_WORDS) * longint'(NSTEP);

   if ((DIM_OUTPUT * OUTPUT_W) % BRAM_DAT_W != 0) begin : g_chk_pack
      $error("fc_result_writer: vector width must be a multiple of BRAM_DAT_W");
   end
   if (SPAN > (longint'(1) << ADDR_SW)) begin : g_chk_span
      $error("fc_result_writer: batch does not fit in the BRAM address space");
   end
   if (BATCH_NUM < 1) begin : g_chk_batch
      $error("fc_result_writer: BATCH_NUM must be at least 1");
   end

   fc_state_t             state, state_nxt;
   logic [OUTPUT_W-1:0]   vec_p0 [DIM_OUTPUT];
   logic [KW-1:0]         word_cnt;
   logic [CW-1:0]         vec_cnt;
   logic [ADDR_SW-1:0]    addr_q;
   logic                  err_q;
   logic                  clr, cap, wr_vec;
   logic                  last_word, last_vec;
   logic [BRAM_DAT_W-1:0] slice_word;
   logic [31:0]           tail_word;

   assign last_word = (word_cnt == KW'(NWORDS - 1));
   assign last_vec  = (vec_cnt == CW'(BATCH_NUM - 1));
   assign tail_word = {TAIL_MAGIC, err_q, 7'd0, 8'(vec_cnt)};

   fc_word_slicer #(
      .DIM_OUTPUT (DIM_OUTPUT),
      .OUTPUT_W   (OUTPUT_W),
      .BRAM_DAT_W (BRAM_DAT_W),
      .WORDS_N    (NWORDS),
      .KW         (KW)
   ) u_slicer (
      .vec  (vec_p0),
      .k    (word_cnt),
      .word (slice_word)
   );

   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      cap       = 1'b0;
      wr_vec    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               clr       = 1'b1;
               state_nxt = ACCEPT;
            end
         end
         ACCEPT: begin
            if (vec_vld) begin
               cap       = 1'b1;
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            wr_vec = 1'b1;
            if (last_word) begin
               if (last_vec) begin
`ifdef FC_RESULT_TAIL_EN
                  state_nxt = TAIL;
`else
                  state_nxt = DONE;
`endif
               end else begin
                  state_nxt = ACCEPT;
               end
            end
         end
         TAIL: begin
            state_nxt = DONE;
         end
         DONE: begin
            // start takes priority over a simultaneous done_ack
            if (start) begin
               clr       = 1'b1;
               state_nxt = ACCEPT;
            end else if (done_ack) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      vec_rdy   = (state == ACCEPT);
      busy      = (state == ACCEPT) || (state == WRITE) || (state == TAIL);
      done      = (state == DONE);
      bram_en   = (state == WRITE) || (state == TAIL);
      bram_we   = bram_en;
      err_drop  = err_q;
      bram_addr = bram_en ? addr_q : '0;
      bram_din  = '0;
      if (state == WRITE) begin
         bram_din = slice_word;
      end else if (state == TAIL) begin
         bram_din = BRAM_DAT_W'(tail_word);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         word_cnt <= '0;
         vec_cnt  <= '0;
         addr_q   <= ADDR_SW'(BASE_ADDR);
         err_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (clr) begin
            word_cnt <= '0;
            vec_cnt  <= '0;
            addr_q   <= ADDR_SW'(BASE_ADDR);
         end else if (wr_vec) begin
            addr_q <= addr_q + ADDR_SW'(NSTEP);
            if (last_word) begin
               word_cnt <= '0;
               vec_cnt  <= vec_cnt + CW'(1);
            end else begin
               word_cnt <= word_cnt + KW'(1);
            end
         end
         if (vec_vld && !vec_rdy) begin
            err_q <= 1'b1;
         end else if (clr) begin
            err_q <= 1'b0;
         end
      end
   end

   // Capture stage: vector data register, no reset needed
   always_ff @(posedge clk) begin
      if (cap) begin
         vec_p0 <= vec_dat;
      end
   end

endmodule

// File: tb/tb_fc_result_writer.sv
// Self-checking bench for fc_result_writer with a write scoreboard and per-vector timing checks.
module tb_fc_result_writer;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b1;
   logic        start    = 1'b0;
   logic        vec_vld  = 1'b0;
   logic        done_ack = 1'b0;
   logic [7:0]  vec_dat [8];
   logic        vec_rdy;
   logic [11:0] bram_addr;
   logic [31:0] bram_din;
   logic        bram_en;
   logic        bram_we;
   logic        busy;
   logic        done;
   logic        err_drop;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] din;
   } wr_t;

   typedef struct {
      int          base;
      logic [11:0] addr0;
      logic [31:0] w0;
      logic [31:0] w1;
      bit          last;
   } vec_t;

   wr_t  sb [$];
   vec_t tbl [10];
   int   n_cmp = 0;
   int   n_bad = 0;

   fc_result_writer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .vec_dat   (vec_dat),
      .vec_vld   (vec_vld),
      .vec_rdy   (vec_rdy),
      .bram_addr (bram_addr),
      .bram_din  (bram_din),
      .bram_en   (bram_en),
      .bram_we   (bram_we),
      .busy      (busy),
      .done      (done),
      .done_ack  (done_ack),
      .err_drop  (err_drop)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pack_word(input int base, input int k);
      logic [31:0] w;
      for (int b = 0; b < 4; b++) begin
         w[b*8 +: 8] = 8'(base + k*4 + b);
      end
      return w;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : mon
      wr_t e;
      if (rst_n === 1'b1 && bram_en === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got write addr %h data %h, expected no write", bram_addr, bram_din);
         end else begin
            e = sb.pop_front();
            chk("wr_addr", 32'(bram_addr), 32'(e.addr));
            chk("wr_data", bram_din, e.din);
            chk("wr_we", 32'(bram_we), 32'd1);
         end
      end
   end

   task automatic wait_rdy();
      int k = 0;
      while (vec_rdy !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("rdy_wait", 32'(vec_rdy), 32'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_vec(input vec_t v, input bit drop);
      for (int i = 0; i < 8; i++) vec_dat[i] = 8'(v.base + i);
      sb.push_back(wr_t'{v.addr0, v.w0});
      sb.push_back(wr_t'{v.addr0 + 12'd4, v.w1});
`ifdef FC_RESULT_TAIL_EN
      if (v.last) sb.push_back(wr_t'{12'h050, 32'hFC5A000A});
`endif
      vec_vld = 1'b1;
      @(negedge clk);
      vec_vld = drop;
      for (int i = 0; i < 8; i++) vec_dat[i] = 8'hEE;
      chk("t1_en", 32'(bram_en), 32'd1);
      chk("t1_rdy", 32'(vec_rdy), 32'd0);
      @(negedge clk);
      vec_vld = 1'b0;
      chk("t2_en", 32'(bram_en), 32'd1);
      chk("t2_rdy", 32'(vec_rdy), 32'd0);
      chk("t2_done", 32'(done), 32'd0);
      @(negedge clk);
      if (v.last) begin
`ifdef FC_RESULT_TAIL_EN
         chk("tail_en", 32'(bram_en), 32'd1);
         chk("tail_done", 32'(done), 32'd0);
         @(negedge clk);
`endif
         chk("last_done", 32'(done), 32'd1);
         chk("last_busy", 32'(busy), 32'd0);
         chk("last_en", 32'(bram_en), 32'd0);
      end else begin
         chk("t3_rdy", 32'(vec_rdy), 32'd1);
         chk("t3_en", 32'(bram_en), 32'd0);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rdy"},  32'(vec_rdy),   32'd0);
      chk({tag, "_addr"}, 32'(bram_addr), 32'd0);
      chk({tag, "_din"},  bram_din,       32'd0);
      chk({tag, "_en"},   32'(bram_en),   32'd0);
      chk({tag, "_we"},   32'(bram_we),   32'd0);
      chk({tag, "_busy"}, 32'(busy),      32'd0);
      chk({tag, "_done"}, 32'(done),      32'd0);
      chk({tag, "_err"},  32'(err_drop),  32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int n = 0; n < 10; n++) begin
         tbl[n] = vec_t'{n*16, 12'(n*8), pack_word(n*16, 0), pack_word(n*16, 1), (n == 9)};
      end
      for (int i = 0; i < 8; i++) vec_dat[i] = 8'h00;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("rst");
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);

      // Nominal batch, vectors spaced 100 cycles apart
      pulse_start();
      chk("arm_busy", 32'(busy), 32'd1);
      chk("arm_rdy", 32'(vec_rdy), 32'd1);
      for (int n = 0; n < 10; n++) begin
         wait_rdy();
         send_vec(tbl[n], 1'b0);
         if (!tbl[n].last) repeat (97) @(negedge clk);
      end
      repeat (5) @(negedge clk);
      chk("done_sticky", 32'(done), 32'd1);
      chk("b1_err", 32'(err_drop), 32'd0);
      chk("b1_sb_empty", 32'(sb.size()), 32'd0);

      done_ack = 1'b1;
      @(negedge clk);
      done_ack = 1'b0;
      chk("ack_done", 32'(done), 32'd0);
      chk("ack_busy", 32'(busy), 32'd0);

      // Drop while idle, then start clears err_drop
      vec_vld = 1'b1;
      @(negedge clk);
      vec_vld = 1'b0;
      chk("idle_drop_err", 32'(err_drop), 32'd1);
      pulse_start();
      chk("start_clr_err", 32'(err_drop), 32'd0);
      chk("start_rdy", 32'(vec_rdy), 32'd1);

      // Drop during WRITE, start and done_ack during ACCEPT ignored
      wait_rdy();
      send_vec(tbl[0], 1'b1);
      chk("write_drop_err", 32'(err_drop), 32'd1);
      pulse_start();
      chk("busy_start_rdy", 32'(vec_rdy), 32'd1);
      chk("busy_start_err", 32'(err_drop), 32'd1);
      done_ack = 1'b1;
      @(negedge clk);
      done_ack = 1'b0;
      chk("stray_ack_busy", 32'(busy), 32'd1);
      wait_rdy();
      send_vec(tbl[1], 1'b0);
      wait_rdy();
      send_vec(tbl[2], 1'b0);

      // Asynchronous reset while vector 3 is being written
      wait_rdy();
      for (int i = 0; i < 8; i++) vec_dat[i] = 8'(tbl[3].base + i);
      sb.push_back(wr_t'{tbl[3].addr0, tbl[3].w0});
      vec_vld = 1'b1;
      @(negedge clk);
      vec_vld = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_sb", 32'(sb.size()), 32'd0);

      // Fresh batch after reset starts at address 0
      pulse_start();
      for (int n = 0; n < 10; n++) begin
         wait_rdy();
         send_vec(tbl[n], 1'b0);
      end

      // start and done_ack together in DONE: start wins
      start    = 1'b1;
      done_ack = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      done_ack = 1'b0;
      chk("both_done", 32'(done), 32'd0);
      chk("both_busy", 32'(busy), 32'd1);
      chk("both_rdy", 32'(vec_rdy), 32'd1);
      wait_rdy();
      send_vec(tbl[0], 1'b0);

      repeat (3) @(negedge clk);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
